// File: rtl/spi_mstr16_if.sv
// Bundle of the dump-machine handshake (wrt/cmd/rdy/rd_data) and the SPI pins.
// The master modport is the SPI master's view; the slave modport is the requester/pin side.
interface spi_mstr16_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        rdy;
    logic [15:0] rd_data;
    logic        MISO;
    logic        SCLK;
    logic        MOSI;
    logic        SS_n;

    modport master (
        input  wrt,
        input  cmd,
        input  MISO,
        output rdy,
        output rd_data,
        output SCLK,
        output MOSI,
        output SS_n
    );

    modport slave (
        output wrt,
        output cmd,
        output MISO,
        input  rdy,
        input  rd_data,
        input  SCLK,
        input  MOSI,
        input  SS_n
    );
endinterface

// File: rtl/spi_mstr16.sv
// 16-bit mode-3 SPI master: SCLK idles high, MOSI changes on fall, MISO sampled on rise.
// One word out / one word in per wrt strobe; rdy high while idle or done.
module spi_mstr16 #(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_mstr16_if.master  bus
);

    localparam int unsigned HALF   = SCLK_DIV / 2;
    localparam int unsigned DIV_W  = $clog2(SCLK_DIV);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BIT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BACK  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_sr;
    logic                r_sample;
    logic                r_sclk;
    logic                r_ss_n;
    logic                r_rdy;
    logic [DATA_W-1:0]   r_rd_data;

    state_t              w_state_nxt;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [BIT_W-1:0]    w_bit_cnt_nxt;
    logic [DATA_W-1:0]   w_sr_nxt;
    logic                w_sample_nxt;
    logic                w_sclk_nxt;
    logic                w_ss_n_nxt;
    logic                w_rdy_nxt;
    logic [DATA_W-1:0]   w_rd_data_nxt;

    logic                w_fall;
    logic                w_rise;
    logic [DIV_W-1:0]    w_div_inc;
    logic [DATA_W-1:0]   w_sr_shift;

    // Divider phase decode: fall at mid-period, rise at end of period (counter wraps there)
    assign w_fall     = (r_div == DIV_W'(HALF - 1));
    assign w_rise     = (r_div == DIV_W'(SCLK_DIV - 1));
    assign w_div_inc  = w_rise ? '0 : r_div + DIV_W'(1);
    assign w_sr_shift = {r_sr[DATA_W-2:0], r_sample};

    // Next-state and datapath control
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sr_nxt      = r_sr;
        w_sample_nxt  = r_sample;
        w_sclk_nxt    = r_sclk;
        w_ss_n_nxt    = r_ss_n;
        w_rdy_nxt     = r_rdy;
        w_rd_data_nxt = r_rd_data;

        unique case (r_state)
            IDLE: begin
                if (bus.wrt) begin
                    w_sr_nxt      = bus.cmd;
                    w_ss_n_nxt    = 1'b0;
                    w_rdy_nxt     = 1'b0;
                    w_div_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = SHIFT;
                end
            end

            SHIFT: begin
                w_div_nxt = w_div_inc;
                if (w_fall) begin
                    w_sclk_nxt = 1'b0;
                    // MSB is already on MOSI before the first fall, so that fall does not shift
                    if (r_bit_cnt != '0) begin
                        w_sr_nxt = w_sr_shift;
                    end
                end
                if (w_rise) begin
                    w_sclk_nxt    = 1'b1;
                    w_sample_nxt  = bus.MISO;
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        w_state_nxt = BACK;
                    end
                end
            end

            BACK: begin
                w_div_nxt = w_div_inc;
                // Half period after the last rise: absorb the last sample and release the slave
                if (w_fall) begin
                    w_sr_nxt      = w_sr_shift;
                    w_rd_data_nxt = w_sr_shift;
                    w_ss_n_nxt    = 1'b1;
                    w_rdy_nxt     = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_sclk_nxt  = 1'b1;
                w_ss_n_nxt  = 1'b1;
                w_rdy_nxt   = 1'b1;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_sr      <= '0;
            r_sample  <= 1'b0;
            r_sclk    <= 1'b1;
            r_ss_n    <= 1'b1;
            r_rdy     <= 1'b1;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sr      <= w_sr_nxt;
            r_sample  <= w_sample_nxt;
            r_sclk    <= w_sclk_nxt;
            r_ss_n    <= w_ss_n_nxt;
            r_rdy     <= w_rdy_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    assign bus.SCLK    = r_sclk;
    assign bus.SS_n    = r_ss_n;
    assign bus.rdy     = r_rdy;
    assign bus.rd_data = r_rd_data;
    assign bus.MOSI    = r_sr[DATA_W-1];

endmodule
